// File: rtl/bambu_mem_channel_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : bambu_mem_channel_arbiter                                         |
// | Brief  : Shares one single-port synchronous RAM between the two master     |
// |          channels of a Bambu core. Each access is one transaction:         |
// |          arbitrate, issue, wait the fixed RAM latency, pulse ready.        |
// | Config : define ARB_FIXED_PRIO_EN to grant every tie to ch0. Without it,   |
// |          ties alternate round-robin.                                       |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module bambu_mem_channel_arbiter #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int SIZE_W  = 6,
  parameter int MEM_LAT = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          ch_oe,
  input  logic [1:0]          ch_we,
  input  logic [2*ADDR_W-1:0] ch_addr,
  input  logic [2*DATA_W-1:0] ch_wdata,
  input  logic [2*SIZE_W-1:0] ch_size,
  output logic [2*DATA_W-1:0] ch_rdata,
  output logic [1:0]          ch_rdy,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W-1:0]   mem_wmask,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err_both
);

  // The counter must hold MEM_LAT itself; a latency of 1 still needs one bit.
  localparam int CNT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                dir_q, dir_d;       // 1 = write
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                last_gnt_q, last_gnt_d;
  logic                err_both_q, err_both_d;

  logic [1:0]          req;
  logic [DATA_W-1:0]   mask;

  // Size in bits to a low-aligned bit mask; sizes at or above the bus width
  // saturate to all ones and size 0 yields an empty mask.
  function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] sz);
    logic [DATA_W:0] one_hot;
    if (int'(sz) >= DATA_W) begin
      return '1;
    end
    one_hot = {{DATA_W{1'b0}}, 1'b1} << sz;
    return one_hot[DATA_W-1:0] - DATA_W'(1);
  endfunction

  assign mask = size_mask(size_q);

  // A channel asserting both oe and we is in conflict and is never eligible.
  assign req = ch_oe ^ ch_we;

  // Next-state logic: arbitration, transaction latching and latency counting.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    dir_d      = dir_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    size_d     = size_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    last_gnt_d = last_gnt_q;
    err_both_d = err_both_q | (|(ch_oe & ch_we));

    case (state_q)
      S_IDLE: begin
        if (|req) begin
          if (req == 2'b11) begin
`ifdef ARB_FIXED_PRIO_EN
            gnt_d = 1'b0;
`else
            gnt_d = ~last_gnt_q;
`endif
          end else begin
            gnt_d = req[1];
          end
          dir_d   = gnt_d ? ch_we[1] : ch_we[0];
          addr_d  = gnt_d ? ch_addr[2*ADDR_W-1:ADDR_W]  : ch_addr[ADDR_W-1:0];
          wdata_d = gnt_d ? ch_wdata[2*DATA_W-1:DATA_W] : ch_wdata[DATA_W-1:0];
          size_d  = gnt_d ? ch_size[2*SIZE_W-1:SIZE_W]  : ch_size[SIZE_W-1:0];
          // Writes complete with zero read data.
          rdata_d = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (dir_q) begin
          state_d = S_RESP;
        end else begin
          cnt_d   = CNT_W'(MEM_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          rdata_d = mem_rdata & mask;
          cnt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        last_gnt_d = gnt_q;
        state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode: RAM side only live in ISSUE, channel side only in RESP.
  always_comb begin
    mem_en    = (state_q == S_ISSUE);
    mem_we    = mem_en & dir_q;
    mem_addr  = mem_en ? addr_q : '0;
    mem_wdata = mem_we ? (wdata_q & mask) : '0;
    mem_wmask = mem_we ? mask : '0;
    ch_rdy    = 2'b00;
    ch_rdata  = '0;
    if (state_q == S_RESP) begin
      ch_rdy = gnt_q ? 2'b10 : 2'b01;
      if (gnt_q) begin
        ch_rdata[2*DATA_W-1:DATA_W] = rdata_q;
      end else begin
        ch_rdata[DATA_W-1:0] = rdata_q;
      end
    end
    err_both = err_both_q;
  end

  // State and transaction registers; reset abandons any transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      dir_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      last_gnt_q <= 1'b1;
      err_both_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      dir_q      <= dir_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      size_q     <= size_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      last_gnt_q <= last_gnt_d;
      err_both_q <= err_both_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bambu_mem_channel_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_bambu_mem_channel_arbiter                                      |
// | Brief  : Directed self-checking bench. Instance a uses MEM_LAT=1, instance |
// |          b uses MEM_LAT=3; each has its own behavioural RAM.               |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_bambu_mem_channel_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic ram_clr;

  // Instance a signals (MEM_LAT = 1)
  logic        a_reset;
  logic [1:0]  a_oe, a_we, a_rdy;
  logic [13:0] a_addr;
  logic [63:0] a_wdata, a_rdata;
  logic [11:0] a_size;
  logic        a_mem_en, a_mem_we, a_err;
  logic [6:0]  a_mem_addr;
  logic [31:0] a_mem_wdata, a_mem_wmask, a_mem_rdata;
  logic [31:0] a_ram [128];

  // Instance b signals (MEM_LAT = 3)
  logic        b_reset;
  logic [1:0]  b_oe, b_we, b_rdy;
  logic [13:0] b_addr;
  logic [63:0] b_wdata, b_rdata;
  logic [11:0] b_size;
  logic        b_mem_en, b_mem_we, b_err;
  logic [6:0]  b_mem_addr;
  logic [31:0] b_mem_wdata, b_mem_wmask, b_mem_rdata, b_p0, b_p1;
  logic [31:0] b_ram [128];

  bambu_mem_channel_arbiter #(.ADDR_W(7), .DATA_W(32), .SIZE_W(6), .MEM_LAT(1)) u_a (
    .clock(clock), .reset(a_reset), .ch_oe(a_oe), .ch_we(a_we), .ch_addr(a_addr),
    .ch_wdata(a_wdata), .ch_size(a_size), .ch_rdata(a_rdata), .ch_rdy(a_rdy),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_wmask(a_mem_wmask), .mem_rdata(a_mem_rdata), .err_both(a_err)
  );

  bambu_mem_channel_arbiter #(.ADDR_W(7), .DATA_W(32), .SIZE_W(6), .MEM_LAT(3)) u_b (
    .clock(clock), .reset(b_reset), .ch_oe(b_oe), .ch_we(b_we), .ch_addr(b_addr),
    .ch_wdata(b_wdata), .ch_size(b_size), .ch_rdata(b_rdata), .ch_rdy(b_rdy),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_wmask(b_mem_wmask), .mem_rdata(b_mem_rdata), .err_both(b_err)
  );

  // RAM a: read data valid only in the single cycle after the read strobe.
  always @(posedge clock) begin
    if (ram_clr) begin
      for (int i = 0; i < 128; i++) a_ram[i] <= 32'h0;
      a_ram[5]    <= 32'hDEADBEEF;
      a_mem_rdata <= 32'h0;
    end else begin
      a_mem_rdata <= 32'h0;
      if (a_mem_en) begin
        if (a_mem_we)
          a_ram[a_mem_addr] <= (a_ram[a_mem_addr] & ~a_mem_wmask) | (a_mem_wdata & a_mem_wmask);
        else
          a_mem_rdata <= a_ram[a_mem_addr];
      end
    end
  end

  // RAM b: three-stage read pipeline, data valid only in cycle ISSUE+3.
  always @(posedge clock) begin
    if (ram_clr) begin
      for (int i = 0; i < 128; i++) b_ram[i] <= 32'h0;
      b_ram[5]    <= 32'hDEADBEEF;
      b_p0        <= 32'h0;
      b_p1        <= 32'h0;
      b_mem_rdata <= 32'h0;
    end else begin
      b_p0        <= (b_mem_en && !b_mem_we) ? b_ram[b_mem_addr] : 32'h0;
      b_p1        <= b_p0;
      b_mem_rdata <= b_p1;
      if (b_mem_en && b_mem_we)
        b_ram[b_mem_addr] <= (b_ram[b_mem_addr] & ~b_mem_wmask) | (b_mem_wdata & b_mem_wmask);
    end
  end

  task automatic a_idle();
    a_oe = 2'b00; a_we = 2'b00; a_addr = '0; a_wdata = '0; a_size = '0;
  endtask

  task automatic b_idle();
    b_oe = 2'b00; b_we = 2'b00; b_addr = '0; b_wdata = '0; b_size = '0;
  endtask

  task automatic a_pulse_reset();
    @(negedge clock);
    a_idle();
    a_reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    a_reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    checks++;
    if ({a_rdata, a_rdy, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_mem_wmask, a_err} !== '0) begin
      errors++;
      $display("FAIL reset_a got rdata=%h rdy=%b en=%b we=%b addr=%h wd=%h wm=%h err=%b exp all 0",
               a_rdata, a_rdy, a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata, a_mem_wmask, a_err);
    end
    checks++;
    if ({b_rdata, b_rdy, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_mem_wmask, b_err} !== '0) begin
      errors++;
      $display("FAIL reset_b got rdata=%h rdy=%b en=%b we=%b addr=%h wd=%h wm=%h err=%b exp all 0",
               b_rdata, b_rdy, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_mem_wmask, b_err);
    end
    ram_clr = 1'b0;
    a_reset = 1'b0;
    b_reset = 1'b0;
  endtask

  // ch0 read of addr 5: strobe in cycle 1, ready in cycle 3.
  task automatic test_read_lat1();
    logic [1:0]  exp_rdy;
    logic [63:0] exp_rd;
    @(negedge clock);
    a_oe = 2'b01; a_addr[6:0] = 7'd5; a_size[5:0] = 6'd32;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      checks++;
      if (a_mem_en !== (c == 1) || a_mem_we !== 1'b0 || a_mem_addr !== ((c == 1) ? 7'd5 : 7'd0)) begin
        errors++;
        $display("FAIL rd1_mem cyc=%0d got en=%b we=%b addr=%h exp en=%b we=0 addr=%h",
                 c, a_mem_en, a_mem_we, a_mem_addr, (c == 1), (c == 1) ? 7'd5 : 7'd0);
      end
      exp_rdy = (c == 3) ? 2'b01 : 2'b00;
      exp_rd  = (c == 3) ? 64'h00000000_DEADBEEF : 64'h0;
      checks++;
      if (a_rdy !== exp_rdy || a_rdata !== exp_rd) begin
        errors++;
        $display("FAIL rd1_resp cyc=%0d got rdy=%b rdata=%h exp rdy=%b rdata=%h",
                 c, a_rdy, a_rdata, exp_rdy, exp_rd);
      end
      if (c == 3) a_oe = 2'b00;
    end
  endtask

  // ch1 byte write to addr 9 then full-width read back.
  task automatic test_write_lat1();
    @(negedge clock);
    a_we = 2'b10; a_addr[13:7] = 7'd9; a_wdata[63:32] = 32'h12345678; a_size[11:6] = 6'd8;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      if (c == 1) begin
        checks++;
        if (a_mem_en !== 1'b1 || a_mem_we !== 1'b1 || a_mem_addr !== 7'd9 ||
            a_mem_wmask !== 32'h000000FF || a_mem_wdata !== 32'h00000078) begin
          errors++;
          $display("FAIL wr_mem got en=%b we=%b addr=%h wm=%h wd=%h exp 1 1 09 000000ff 00000078",
                   a_mem_en, a_mem_we, a_mem_addr, a_mem_wmask, a_mem_wdata);
        end
      end
      checks++;
      if (a_rdy !== ((c == 2) ? 2'b10 : 2'b00) || a_rdata !== 64'h0) begin
        errors++;
        $display("FAIL wr_resp cyc=%0d got rdy=%b rdata=%h exp rdy=%b rdata=0",
                 c, a_rdy, a_rdata, (c == 2) ? 2'b10 : 2'b00);
      end
      if (c == 2) a_we = 2'b00;
    end
    a_oe = 2'b10; a_size[11:6] = 6'd32;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clock);
      if (c == 3) begin
        checks++;
        if (a_rdy !== 2'b10 || a_rdata !== 64'h00000078_00000000) begin
          errors++;
          $display("FAIL wr_readback got rdy=%b rdata=%h exp rdy=10 rdata=0000007800000000",
                   a_rdy, a_rdata);
        end
        a_oe = 2'b00;
      end
    end
  endtask

  // Read masks for sizes 16, 0 and 40, then a size-0 write that must not disturb RAM.
  task automatic test_mask();
    logic [5:0]  sz [3];
    logic [31:0] ex [3];
    sz[0] = 6'd16; ex[0] = 32'h0000BEEF;
    sz[1] = 6'd0;  ex[1] = 32'h00000000;
    sz[2] = 6'd40; ex[2] = 32'hDEADBEEF;
    for (int t = 0; t < 3; t++) begin
      @(negedge clock);
      a_oe = 2'b01; a_addr[6:0] = 7'd5; a_size[5:0] = sz[t];
      for (int c = 1; c <= 4; c++) begin
        @(negedge clock);
        if (c == 3) begin
          checks++;
          if (a_rdy !== 2'b01 || a_rdata !== {32'h0, ex[t]}) begin
            errors++;
            $display("FAIL mask_read size=%0d got rdy=%b rdata=%h exp rdy=01 rdata=%h",
                     sz[t], a_rdy, a_rdata, {32'h0, ex[t]});
          end
          a_oe = 2'b00;
        end
      end
    end
    @(negedge clock);
    a_we = 2'b01; a_addr[6:0] = 7'd5; a_wdata[31:0] = 32'hFFFFFFFF; a_size[5:0] = 6'd0;
    @(negedge clock);
    checks++;
    if (a_mem_en !== 1'b1 || a_mem_we !== 1'b1 || a_mem_wmask !== 32'h0 || a_mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL mask_wr0 got en=%b we=%b wm=%h wd=%h exp 1 1 0 0",
               a_mem_en, a_mem_we, a_mem_wmask, a_mem_wdata);
    end
    @(negedge clock);
    a_we = 2'b00;
  endtask

  // Both channels hold read requests across four grants: order must alternate 0,1,0,1.
  task automatic test_round_robin();
    int n = 0;
    int en_cnt = 0;
    int bad_rdy = 0;
    logic        g;
    logic [63:0] exp_rd;
    a_pulse_reset();
    a_oe = 2'b11; a_addr = {7'd9, 7'd5}; a_size = {6'd32, 6'd32};
    for (int c = 1; c <= 40 && n < 4; c++) begin
      @(negedge clock);
      if (a_mem_en === 1'b1) en_cnt++;
      if (a_rdy === 2'b11) bad_rdy++;
      if (a_rdy !== 2'b00) begin
        g = a_rdy[1];
        exp_rd = (n % 2 == 1) ? 64'h00000078_00000000 : 64'h00000000_DEADBEEF;
        checks++;
        if (g !== ((n % 2) == 1) || a_rdata !== exp_rd) begin
          errors++;
          $display("FAIL rr_grant idx=%0d got ch=%0d rdata=%h exp ch=%0d rdata=%h",
                   n, g, a_rdata, n % 2, exp_rd);
        end
        n++;
        if (n == 4) a_oe = 2'b00;
      end
    end
    checks++;
    if (n != 4 || en_cnt != 4 || bad_rdy != 0) begin
      errors++;
      $display("FAIL rr_count got grants=%0d mem_en=%0d dual_rdy=%0d exp 4 4 0", n, en_cnt, bad_rdy);
    end
  endtask

  // ch0 drives oe and we together; ch1 read must still be served.
  task automatic test_err_both();
    int en_cnt = 0;
    int rdy0 = 0;
    a_pulse_reset();
    a_oe = 2'b11; a_we = 2'b01; a_addr = {7'd5, 7'd5}; a_size = {6'd32, 6'd32};
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (a_mem_en === 1'b1) en_cnt++;
      if (a_rdy[0] === 1'b1) rdy0++;
      if (c == 1) begin
        checks++;
        if (a_err !== 1'b1 || a_mem_en !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 7'd5) begin
          errors++;
          $display("FAIL err_set got err=%b en=%b we=%b addr=%h exp 1 1 0 05",
                   a_err, a_mem_en, a_mem_we, a_mem_addr);
        end
      end
      if (c == 3) begin
        checks++;
        if (a_rdy !== 2'b10 || a_rdata !== 64'hDEADBEEF_00000000) begin
          errors++;
          $display("FAIL err_ch1 got rdy=%b rdata=%h exp rdy=10 rdata=deadbeef00000000", a_rdy, a_rdata);
        end
        a_oe[1] = 1'b0;
      end
    end
    a_idle();
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (en_cnt != 1 || rdy0 != 0 || a_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky got mem_en=%0d rdy0=%0d err=%b exp 1 0 1", en_cnt, rdy0, a_err);
    end
  endtask

  // MEM_LAT=3 read: ready exactly 5 cycles after the request, rdata zero elsewhere.
  task automatic test_latency3();
    logic [1:0]  exp_rdy;
    logic [63:0] exp_rd;
    @(negedge clock);
    b_oe = 2'b01; b_addr[6:0] = 7'd5; b_size[5:0] = 6'd32;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clock);
      exp_rdy = (c == 5) ? 2'b01 : 2'b00;
      exp_rd  = (c == 5) ? 64'h00000000_DEADBEEF : 64'h0;
      checks++;
      if (b_rdy !== exp_rdy || b_rdata !== exp_rd || b_mem_en !== (c == 1)) begin
        errors++;
        $display("FAIL lat3 cyc=%0d got rdy=%b rdata=%h en=%b exp rdy=%b rdata=%h en=%b",
                 c, b_rdy, b_rdata, b_mem_en, exp_rdy, exp_rd, (c == 1));
      end
      if (c == 5) b_oe = 2'b00;
    end
  endtask

  // Reset during WAIT drops the read; the next tie goes to ch0 again.
  task automatic test_reset_mid();
    int stray = 0;
    logic [1:0]  exp_rdy;
    logic [63:0] exp_rd;
    @(negedge clock);
    b_oe = 2'b10; b_addr[13:7] = 7'd5; b_size[11:6] = 6'd32;
    @(negedge clock);
    @(negedge clock);
    b_reset = 1'b1;
    b_idle();
    @(negedge clock);
    checks++;
    if ({b_rdata, b_rdy, b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata, b_mem_wmask, b_err} !== '0) begin
      errors++;
      $display("FAIL rstmid_out got rdata=%h rdy=%b en=%b we=%b addr=%h exp all 0",
               b_rdata, b_rdy, b_mem_en, b_mem_we, b_mem_addr);
    end
    b_reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (b_rdy !== 2'b00 || b_mem_en !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL rstmid_quiet got stray_cycles=%0d exp 0", stray);
    end
    b_oe = 2'b11; b_addr = {7'd9, 7'd5}; b_size = {6'd32, 6'd32};
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      exp_rdy = (c == 5) ? 2'b01 : 2'b00;
      exp_rd  = (c == 5) ? 64'h00000000_DEADBEEF : 64'h0;
      checks++;
      if (b_rdy !== exp_rdy || b_rdata !== exp_rd) begin
        errors++;
        $display("FAIL rstmid_tie cyc=%0d got rdy=%b rdata=%h exp rdy=%b rdata=%h",
                 c, b_rdy, b_rdata, exp_rdy, exp_rd);
      end
      if (c == 5) b_oe = 2'b00;
    end
  endtask

  initial begin
    ram_clr = 1'b1;
    a_reset = 1'b1;
    b_reset = 1'b1;
    a_idle();
    b_idle();
    repeat (3) @(negedge clock);
    test_reset();
    test_read_lat1();
    test_write_lat1();
    test_mask();
    test_round_robin();
    test_err_both();
    test_latency3();
    test_reset_mid();
    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
